mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage directly downstream of the EX/MEM register; consumes the ALU result, load/store op, effective address and store data produced by the execute stage.
- Issues data-bus transactions for LB/LBU/LH/LHU/LW/SB/SH/SW through a req/ack handshake and stalls the pipeline until completion.
- Forwards the register write-back and HI/LO write to MEM/WB, and exposes the HI/LO write as the MEM-stage bypass into execute.

Parameters:
- ALUOP_W, 8, width of alu_op_i; must match `ALUOpBus.
- TIMEOUT_CYCLES, 16, bus watchdog limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  stage clock
- rst  in  1  asynchronous, active-low reset
- alu_op_i  in  ALUOP_W  operation code from EX/MEM
- wrn_i  in  1  register write enable
- wrAddr_i  in  5  destination register
- result_i  in  32  ALU result
- mem_addr_i  in  32  effective address
- mem_data_i  in  32  store data (rt)
- wrn_HILO_i  in  1  HI/LO write enable
- wrData_HI_i  in  32  HI write data
- wrData_LO_i  in  32  LO write data
- dbus_rdata  in  32  bus read data
- dbus_ack  in  1  bus transfer complete
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  32  word address, bits [1:0] forced to 0
- dbus_be  out  4  byte enables, bit3 = bits [31:24]
- dbus_wdata  out  32  lane-replicated store data
- stall_req  out  1  freeze IF..MEM
- wrn_o  out  1  write enable to MEM/WB
- wrAddr_o  out  5  destination register to MEM/WB
- wrData_o  out  32  write-back data
- wrn_HILO_o  out  1  HI/LO write enable to MEM/WB and EX bypass
- wrData_HI_o  out  32  HI data to MEM/WB and EX bypass
- wrData_LO_o  out  32  LO data to MEM/WB and EX bypass
- addr_err_o  out  1  misaligned-access pulse
- bus_err_o  out  1  bus timeout pulse

Behaviour:
- Reset (rst = 0, asynchronous):
  - State = IDLE.
  - All outputs are 0; captured read data is 0.
- Big-endian byte lanes:
  - addr[1:0] = 00 selects bits [31:24]; 11 selects bits [7:0].
  - Halfword at 00 selects bits [31:16]; halfword at 10 selects bits [15:0].
- Store data replication:
  - SB: byte replicated to all four lanes.
  - SH: halfword replicated to both halves.
  - SW: word as-is.
- Alignment:
  - LH, LHU, SH require addr[0] = 0.
  - LW, SW require addr[1:0] = 00.
  - Misaligned access: no bus request, wrn_o = 0, addr_err_o = 1 combinationally, stall_req = 0, state stays IDLE.
- Non-memory ops: combinational pass-through; wrData_o = result_i, wrn_o/wrAddr_o/HILO follow their inputs, stall_req = 0.
- State machine: IDLE, BUSY, DONE.
  - IDLE with an aligned memory op:
    - dbus_req = 1 and stall_req = 1, both combinational.
    - Bus fields are driven combinationally from the inputs.
    - Next state: DONE if dbus_ack = 1 at the edge, else BUSY.
  - BUSY:
    - dbus_req and stall_req stay 1.
    - Bus fields stay stable; the inputs are frozen by the stall.
    - Next state is DONE on the edge where dbus_ack = 1.
  - On the ack edge: dbus_rdata is captured into an internal register.
  - DONE (one cycle):
    - dbus_req = 0, stall_req = 0.
    - Load: wrData_o = extended captured data. LB/LH sign-extend; LBU/LHU zero-extend.
    - Store: wrn_o = wrn_i (decoder clears it).
    - Next state IDLE unconditionally; the pipeline advances at this edge.
- Minimum latency: 1 stall cycle with zero-wait ack. Each added wait cycle adds 1 stall cycle.
- dbus_ack in IDLE without a request, or in DONE, is ignored.
- While stall_req = 1: wrn_o = 0 and wrn_HILO_o = 0, so nothing commits twice.
- Reset mid-transaction: immediate return to IDLE, req drops, captured data cleared.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 without ack: go to DONE with bus_err_o = 1 for that cycle, wrn_o = 0, and captured data held at 0.
- Undefined: no counter; BUSY waits indefinitely; bus_err_o tied to 0.

Test Plan:
- ADDU pass-through, result_i = 32'h1234_5678, wrn_i = 1, wrAddr_i = 5 -> same cycle wrData_o = 32'h1234_5678, wrn_o = 1, wrAddr_o = 5, stall_req = 0.
- LB at addr 32'h0000_1003, ack after 2 wait cycles, rdata = 32'h0000_0080:
  - dbus_addr = 32'h0000_1000, dbus_be = 4'b0001.
  - stall_req high for 3 cycles.
  - DONE: wrData_o = 32'hFFFF_FF80.
  - Same case as LBU -> 32'h0000_0080.
- SH at addr 32'h0000_2002, mem_data_i = 32'hAAAA_BEEF, zero-wait ack -> dbus_we = 1, dbus_be = 4'b0011, dbus_wdata = 32'hBEEF_BEEF, exactly one stall cycle.
- LW at addr 32'h0000_0006 -> dbus_req never asserted, addr_err_o = 1, wrn_o = 0, stall_req = 0.
- rst = 0 asserted while in BUSY, mid-transaction -> outputs 0 immediately; after release, a new LW completes normally.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, ack never given -> bus_err_o pulses once after 4 BUSY cycles, wrn_o = 0, state back to IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: big-endian data-bus access (req/ack), load extension, and
// write-back/HI-LO forwarding. Optional bus watchdog enabled by `define MEM_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer pending; pass-through, or request issued for an aligned memory op
// BUSY   | request held, waiting for dbus_ack (pipeline stalled)
// DONE   | transfer complete for one cycle; load data or error presented to MEM/WB
module mem_access_stage #(
   parameter int ALUOP_W        = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ALUOP_W-1:0] alu_op_i,
   input  logic               wrn_i,
   input  logic [4:0]         wrAddr_i,
   input  logic [31:0]        result_i,
   input  logic [31:0]        mem_addr_i,
   input  logic [31:0]        mem_data_i,
   input  logic               wrn_HILO_i,
   input  logic [31:0]        wrData_HI_i,
   input  logic [31:0]        wrData_LO_i,
   input  logic [31:0]        dbus_rdata,
   input  logic               dbus_ack,
   output logic               dbus_req,
   output logic               dbus_we,
   output logic [31:0]        dbus_addr,
   output logic [3:0]         dbus_be,
   output logic [31:0]        dbus_wdata,
   output logic               stall_req,
   output logic               wrn_o,
   output logic [4:0]         wrAddr_o,
   output logic [31:0]        wrData_o,
   output logic               wrn_HILO_o,
   output logic [31:0]        wrData_HI_o,
   output logic [31:0]        wrData_LO_o,
   output logic               addr_err_o,
   output logic               bus_err_o
);

   localparam logic [ALUOP_W-1:0] OP_LB  = ALUOP_W'(8'b1110_0000);
   localparam logic [ALUOP_W-1:0] OP_LBU = ALUOP_W'(8'b1110_0100);
   localparam logic [ALUOP_W-1:0] OP_LH  = ALUOP_W'(8'b1110_0001);
   localparam logic [ALUOP_W-1:0] OP_LHU = ALUOP_W'(8'b1110_0101);
   localparam logic [ALUOP_W-1:0] OP_LW  = ALUOP_W'(8'b1110_0011);
   localparam logic [ALUOP_W-1:0] OP_SB  = ALUOP_W'(8'b1110_1000);
   localparam logic [ALUOP_W-1:0] OP_SH  = ALUOP_W'(8'b1110_1001);
   localparam logic [ALUOP_W-1:0] OP_SW  = ALUOP_W'(8'b1110_1011);

   if (TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("mem_access_stage: TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   logic        is_byte, is_half, is_word, is_load, is_store, is_mem, is_signed;
   logic        misalign;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   always_comb begin
      is_byte   = (alu_op_i == OP_LB) || (alu_op_i == OP_LBU) || (alu_op_i == OP_SB);
      is_half   = (alu_op_i == OP_LH) || (alu_op_i == OP_LHU) || (alu_op_i == OP_SH);
      is_word   = (alu_op_i == OP_LW) || (alu_op_i == OP_SW);
      is_store  = (alu_op_i == OP_SB) || (alu_op_i == OP_SH) || (alu_op_i == OP_SW);
      is_load   = (is_byte || is_half || is_word) && !is_store;
      is_mem    = is_load || is_store;
      is_signed = (alu_op_i == OP_LB) || (alu_op_i == OP_LH);
      misalign  = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
   end

   // Big-endian lanes: offset 0 is the most significant byte.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = mem_data_i;
      if (is_byte) begin
         be_c    = 4'b1000 >> mem_addr_i[1:0];
         wdata_c = {4{mem_data_i[7:0]}};
      end else if (is_half) begin
         be_c    = mem_addr_i[1] ? 4'b0011 : 4'b1100;
         wdata_c = {2{mem_data_i[15:0]}};
      end
   end

   always_comb begin
      case (mem_addr_i[1:0])
         2'b00:   ld_byte = rdata_q[31:24];
         2'b01:   ld_byte = rdata_q[23:16];
         2'b10:   ld_byte = rdata_q[15:8];
         default: ld_byte = rdata_q[7:0];
      endcase
      ld_half = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
      if (is_byte)
         ld_ext = {{24{is_signed & ld_byte[7]}}, ld_byte};
      else if (is_half)
         ld_ext = {{16{is_signed & ld_half[15]}}, ld_half};
      else
         ld_ext = rdata_q;
   end

   logic        req_c, we_c, stall_c, wrn_c, hilo_c, addr_err_c;
   logic [31:0] addr_c, bus_wdata_c, wrdata_c;
   logic [3:0]  bus_be_c;

   always_comb begin
      state_d     = state_q;
      rdata_d     = rdata_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = 1'b0;
`endif
      req_c       = 1'b0;
      we_c        = 1'b0;
      addr_c      = 32'h0;
      bus_be_c    = 4'h0;
      bus_wdata_c = 32'h0;
      stall_c     = 1'b0;
      wrn_c       = wrn_i;
      hilo_c      = wrn_HILO_i;
      wrdata_c    = result_i;
      addr_err_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (is_mem && misalign) begin
               addr_err_c = 1'b1;
               wrn_c      = 1'b0;
            end else if (is_mem) begin
               req_c   = 1'b1;
               stall_c = 1'b1;
               if (dbus_ack) begin
                  state_d = S_DONE;
                  rdata_d = dbus_rdata;
               end else begin
                  state_d = S_BUSY;
`ifdef MEM_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         S_BUSY: begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            if (dbus_ack) begin
               state_d = S_DONE;
               rdata_d = dbus_rdata;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               rdata_d = 32'h0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (is_load)
               wrdata_c = ld_ext;
`ifdef MEM_TIMEOUT_EN
            if (err_q)
               wrn_c = 1'b0;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (req_c) begin
         we_c        = is_store;
         addr_c      = {mem_addr_i[31:2], 2'b00};
         bus_be_c    = be_c;
         bus_wdata_c = wdata_c;
      end

      // Stalled instructions must not commit until DONE.
      if (stall_c) begin
         wrn_c  = 1'b0;
         hilo_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         rdata_q <= 32'h0;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   // Outputs are forced low for as long as reset is asserted, not just at the edge.
   assign dbus_req    = rst & req_c;
   assign dbus_we     = rst & we_c;
   assign dbus_addr   = {32{rst}} & addr_c;
   assign dbus_be     = {4{rst}} & bus_be_c;
   assign dbus_wdata  = {32{rst}} & bus_wdata_c;
   assign stall_req   = rst & stall_c;
   assign wrn_o       = rst & wrn_c;
   assign wrAddr_o    = {5{rst}} & wrAddr_i;
   assign wrData_o    = {32{rst}} & wrdata_c;
   assign wrn_HILO_o  = rst & hilo_c;
   assign wrData_HI_o = {32{rst}} & wrData_HI_i;
   assign wrData_LO_o = {32{rst}} & wrData_LO_i;
   assign addr_err_o  = rst & addr_err_c;
`ifdef MEM_TIMEOUT_EN
   assign bus_err_o   = rst & err_q;
`else
   assign bus_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; the watchdog case runs
// only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_ADDU = 8'b0010_0001;
   localparam logic [7:0] OP_LB   = 8'b1110_0000;
   localparam logic [7:0] OP_LBU  = 8'b1110_0100;
   localparam logic [7:0] OP_LH   = 8'b1110_0001;
   localparam logic [7:0] OP_LHU  = 8'b1110_0101;
   localparam logic [7:0] OP_LW   = 8'b1110_0011;
   localparam logic [7:0] OP_SB   = 8'b1110_1000;
   localparam logic [7:0] OP_SH   = 8'b1110_1001;
   localparam logic [7:0] OP_SW   = 8'b1110_1011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  alu_op;
   logic        wrn;
   logic [4:0]  wr_addr;
   logic [31:0] result, mem_addr, mem_data;
   logic        wrn_hilo;
   logic [31:0] hi_data, lo_data;
   logic [31:0] rdata;
   logic        ack;
   logic        dbus_req, dbus_we, stall_req, wrn_o, wrn_hilo_o, addr_err_o, bus_err_o;
   logic [31:0] dbus_addr, dbus_wdata, wrdata_o, hi_o, lo_o;
   logic [3:0]  dbus_be;
   logic [4:0]  wraddr_o;

   int checks = 0;
   int failures = 0;

   // values observed by run_txn
   int          stalls;
   logic [31:0] first_addr, first_wdata, done_data;
   logic [3:0]  first_be;
   logic        first_we, done_wrn, done_err, done_stall;

   always #5 clk = ~clk;

   mem_access_stage #(.ALUOP_W(8), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst_n),
      .alu_op_i(alu_op), .wrn_i(wrn), .wrAddr_i(wr_addr), .result_i(result),
      .mem_addr_i(mem_addr), .mem_data_i(mem_data),
      .wrn_HILO_i(wrn_hilo), .wrData_HI_i(hi_data), .wrData_LO_i(lo_data),
      .dbus_rdata(rdata), .dbus_ack(ack),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
      .dbus_wdata(dbus_wdata), .stall_req(stall_req),
      .wrn_o(wrn_o), .wrAddr_o(wraddr_o), .wrData_o(wrdata_o),
      .wrn_HILO_o(wrn_hilo_o), .wrData_HI_o(hi_o), .wrData_LO_o(lo_o),
      .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_op = OP_NOP; wrn = 1'b0; wr_addr = 5'd0; result = 32'h0;
      mem_addr = 32'h0; mem_data = 32'h0; wrn_hilo = 1'b0;
      hi_data = 32'h0; lo_data = 32'h0; rdata = 32'h0; ack = 1'b0;
   endtask

   // Holds a memory op until the stall drops; ack arrives after 'waits' wait cycles.
   // During DONE the bus data is inverted so only the captured word can appear.
   task automatic run_txn(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic wr_en,
                          input int waits, input logic [31:0] rd);
      alu_op = op; mem_addr = addr; mem_data = wdata; wrn = wr_en; wr_addr = 5'd9;
      result = 32'h0BAD_0BAD;
      ack = (waits == 0);
      rdata = (waits == 0) ? rd : ~rd;
      #1;
      first_addr = dbus_addr; first_be = dbus_be; first_we = dbus_we; first_wdata = dbus_wdata;
      stalls = 0;
      while (stall_req && stalls < 40) begin
         stalls++;
         @(posedge clk);
         #1;
         ack = (stalls == waits);
         rdata = (stalls == waits) ? rd : ~rd;
         #1;
      end
      if (stalls >= 40) check("txn_cycle_bound", 32'(stalls), 32'd39);
      done_data = wrdata_o; done_wrn = wrn_o; done_err = bus_err_o; done_stall = dbus_req;
      next_cycle();
      idle_inputs();
      #1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      result = 32'hDEAD_BEEF; wrn = 1'b1; wr_addr = 5'd7;
      #2;
      check("rst_wrdata", wrdata_o, 32'h0);
      check("rst_wrn", {31'h0, wrn_o}, 32'h0);
      check("rst_req", {31'h0, dbus_req}, 32'h0);
      check("rst_stall", {31'h0, stall_req}, 32'h0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      idle_inputs();
      next_cycle();

      // ALU pass-through with HI/LO
      alu_op = OP_ADDU; result = 32'h1234_5678; wrn = 1'b1; wr_addr = 5'd5;
      wrn_hilo = 1'b1; hi_data = 32'h1111_2222; lo_data = 32'h3333_4444;
      #1;
      check("addu_data", wrdata_o, 32'h1234_5678);
      check("addu_wrn", {31'h0, wrn_o}, 32'h1);
      check("addu_waddr", {27'h0, wraddr_o}, 32'd5);
      check("addu_stall", {31'h0, stall_req}, 32'h0);
      check("addu_hilo_we", {31'h0, wrn_hilo_o}, 32'h1);
      check("addu_hi", hi_o, 32'h1111_2222);
      check("addu_lo", lo_o, 32'h3333_4444);

      // ack while idle must be ignored
      idle_inputs();
      ack = 1'b1;
      #1;
      check("idle_ack_req", {31'h0, dbus_req}, 32'h0);
      next_cycle();
      ack = 1'b0;
      #1;
      check("idle_ack_stall", {31'h0, stall_req}, 32'h0);
      next_cycle();

      // LB / LBU at byte 3, two wait cycles
      run_txn(OP_LB, 32'h0000_1003, 32'h0, 1'b1, 2, 32'h0000_0080);
      check("lb_addr", first_addr, 32'h0000_1000);
      check("lb_be", {28'h0, first_be}, 32'h1);
      check("lb_we", {31'h0, first_we}, 32'h0);
      check("lb_stalls", 32'(stalls), 32'd3);
      check("lb_data", done_data, 32'hFFFF_FF80);
      check("lb_wrn", {31'h0, done_wrn}, 32'h1);
      check("lb_done_req", {31'h0, done_stall}, 32'h0);
      run_txn(OP_LBU, 32'h0000_1003, 32'h0, 1'b1, 2, 32'h0000_0080);
      check("lbu_data", done_data, 32'h0000_0080);
      check("lbu_stalls", 32'(stalls), 32'd3);

      // SH zero-wait
      run_txn(OP_SH, 32'h0000_2002, 32'hAAAA_BEEF, 1'b0, 0, 32'h0);
      check("sh_we", {31'h0, first_we}, 32'h1);
      check("sh_be", {28'h0, first_be}, 32'h3);
      check("sh_wdata", first_wdata, 32'hBEEF_BEEF);
      check("sh_addr", first_addr, 32'h0000_2000);
      check("sh_stalls", 32'(stalls), 32'd1);
      check("sh_wrn", {31'h0, done_wrn}, 32'h0);

      run_txn(OP_SB, 32'h0000_3001, 32'h1234_56A5, 1'b0, 1, 32'h0);
      check("sb_be", {28'h0, first_be}, 32'h4);
      check("sb_wdata", first_wdata, 32'hA5A5_A5A5);
      check("sb_stalls", 32'(stalls), 32'd2);

      run_txn(OP_SW, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 0, 32'h0);
      check("sw_be", {28'h0, first_be}, 32'hF);
      check("sw_wdata", first_wdata, 32'hCAFE_F00D);

      run_txn(OP_LH, 32'h0000_0042, 32'h0, 1'b1, 0, 32'h1234_8001);
      check("lh_be", {28'h0, first_be}, 32'h3);
      check("lh_data", done_data, 32'hFFFF_8001);
      run_txn(OP_LHU, 32'h0000_0040, 32'h0, 1'b1, 1, 32'h8001_1234);
      check("lhu_be", {28'h0, first_be}, 32'hC);
      check("lhu_data", done_data, 32'h0000_8001);
      run_txn(OP_LW, 32'h0000_0100, 32'h0, 1'b1, 3, 32'h7654_3210);
      check("lw_data", done_data, 32'h7654_3210);
      check("lw_stalls", 32'(stalls), 32'd4);
      check("lw_buserr", {31'h0, done_err}, 32'h0);

      // Misaligned LW
      alu_op = OP_LW; mem_addr = 32'h0000_0006; wrn = 1'b1; wr_addr = 5'd3;
      #1;
      check("mis_req", {31'h0, dbus_req}, 32'h0);
      check("mis_err", {31'h0, addr_err_o}, 32'h1);
      check("mis_wrn", {31'h0, wrn_o}, 32'h0);
      check("mis_stall", {31'h0, stall_req}, 32'h0);
      next_cycle();
      check("mis_req_2", {31'h0, dbus_req}, 32'h0);
      check("mis_err_2", {31'h0, addr_err_o}, 32'h1);
      alu_op = OP_LH; mem_addr = 32'h0000_0003;
      #1;
      check("mis_lh_err", {31'h0, addr_err_o}, 32'h1);
      idle_inputs();
      next_cycle();

      // HI/LO write held back while stalled
      alu_op = OP_LW; mem_addr = 32'h0000_0010; wrn = 1'b1; wrn_hilo = 1'b1;
      #1;
      check("stall_hilo", {31'h0, wrn_hilo_o}, 32'h0);

      // Reset during BUSY
      next_cycle();
      check("busy_stall", {31'h0, stall_req}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", {31'h0, dbus_req}, 32'h0);
      check("mid_rst_stall", {31'h0, stall_req}, 32'h0);
      check("mid_rst_wrn", {31'h0, wrn_o}, 32'h0);
      check("mid_rst_addr", dbus_addr, 32'h0);
      next_cycle();
      rst_n = 1'b1;
      idle_inputs();
      next_cycle();
      run_txn(OP_LW, 32'h0000_0010, 32'h0, 1'b1, 0, 32'h5555_AAAA);
      check("post_rst_stalls", 32'(stalls), 32'd1);
      check("post_rst_data", done_data, 32'h5555_AAAA);

`ifdef MEM_TIMEOUT_EN
      run_txn(OP_LW, 32'h0000_0020, 32'h0, 1'b1, 1000, 32'h0);
      check("to_stalls", 32'(stalls), 32'd5);
      check("to_buserr", {31'h0, done_err}, 32'h1);
      check("to_wrn", {31'h0, done_wrn}, 32'h0);
      check("to_data", done_data, 32'h0);
      check("to_buserr_clr", {31'h0, bus_err_o}, 32'h0);
      check("to_idle_stall", {31'h0, stall_req}, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
